pc_sequencer: RTL

Fetch/redirect controller that drives the next-address input of the program counter in the 16-bit RISC core. Sequences instruction fetch against instruction memory with a req/ack handshake. Selects the next PC: sequential, branch, jump, call or return. Holds a small return-address stack (RAS) for call/ret.

---
 rtl/pc_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/redirect controller for the 16-bit RISC core.
// Drives the program counter's next-address input, runs the instruction
// memory req/ack handshake and keeps a small return-address stack.
//
//   state | meaning
//   FETCH | imem_req high, PC held, waiting for imem_ack
//   ISSUE | instruction valid; control inputs pick the next PC
//   HALT  | fetching stopped, PC held; only rst leaves
module pc_sequencer #(
  parameter int AW        = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  output logic [AW-1:0] target,
  output logic          imem_req,
  input  logic          imem_ack,
  output logic          instr_valid,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_addr,
  input  logic          jump,
  input  logic          call,
  input  logic [AW-1:0] jmp_addr,
  input  logic          ret,
  input  logic          halt,
  output logic          halted,
  output logic          ras_ovf,
  output logic          ras_unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [CW-1:0] ras_cnt;
  logic [CW-1:0] ras_cnt_m1;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] push_idx;
  logic [AW-1:0] ras_top;
  logic          ras_empty;
  logic          ras_full;

  logic [AW-1:0] pc_inc;
  logic          do_push;
  logic          do_pop;
  logic          set_ovf;
  logic          set_unf;

  // Sequential PC and the stack pointers derived from the entry count.
  always_comb begin
    pc_inc     = pc_in + AW'(1);
    ras_cnt_m1 = ras_cnt - CW'(1);
    top_idx    = ras_cnt_m1[PW-1:0];
    push_idx   = ras_cnt[PW-1:0];
    ras_top    = ras_mem[top_idx];
    ras_empty  = (ras_cnt == '0);
    ras_full   = (ras_cnt == CW'(RAS_DEPTH));
  end

  // Next-state, next-PC and stack-operation decode; rst forces a quiet bus.
  always_comb begin
    state_nxt   = state;
    target      = pc_in;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;

    if (rst) begin
      target    = '0;
      state_nxt = ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            state_nxt = ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          instr_valid = 1'b1;
          if (halt) begin
            state_nxt = ST_HALT;
          end else if (stall) begin
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_FETCH;
            if (ret) begin
              if (!ras_empty) begin
                target = ras_top;
                do_pop = 1'b1;
              end else begin
                target  = pc_inc;
                set_unf = 1'b1;
              end
            end else if (call) begin
              target = jmp_addr;
              // A full stack keeps its contents; the lost return is flagged.
              if (ras_full) begin
                set_ovf = 1'b1;
              end else begin
                do_push = 1'b1;
              end
            end else if (jump) begin
              target = jmp_addr;
            end else if (br_taken) begin
              target = br_addr;
            end else begin
              target = pc_inc;
            end
          end
        end

        ST_HALT: begin
          halted = 1'b1;
        end

        default: begin
          state_nxt = ST_FETCH;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Stack occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_cnt <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      if (do_push) begin
        ras_cnt <= ras_cnt + CW'(1);
      end else if (do_pop) begin
        ras_cnt <= ras_cnt_m1;
      end
      if (set_ovf) begin
        ras_ovf <= 1'b1;
      end
      if (set_unf) begin
        ras_unf <= 1'b1;
      end
    end
  end

  // Stack storage; entries above the count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[push_idx] <= pc_inc;
    end
  end

endmodule
